// File: rtl/deb_pkg.sv
// Shared types and helpers for the deb input conditioner.
package deb_pkg;

    // Qualifier states: two stable levels, each with a "checking the other level" state.
    typedef enum logic [1:0] {
        ST_LO  = 2'd0,
        CHK_HI = 2'd1,
        ST_HI  = 2'd2,
        CHK_LO = 2'd3
    } deb_state_t;

    // Counter width able to hold values up to n.
    function automatic int deb_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/deb_sync_ff.sv
// Plain multi-flop synchroniser for a single asynchronous bit; reusable by any block.
module sync_ff #(
    parameter int   S    = 2,
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* syn_preserve = 1, async_reg = "true" *) logic [S-1:0] chain_q;

    // Straight shift chain with no logic between stages; stage 0 takes the raw input.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {S{INIT}};
        end else begin
            chain_q <= {chain_q[S-2:0], d};
        end
    end

    assign q = chain_q[S-1];

endmodule

// File: rtl/deb.sv
// Debouncer: synchronises a bouncy input, requires N stable cycles before the
// level output follows, and emits registered one-cycle rise/fall strobes.
module deb
    import deb_pkg::*;
#(
    parameter int   N    = 16,
    parameter int   S    = 2,
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int             CW      = deb_cnt_w(N);
    localparam logic [CW-1:0]  CNT_MAX = CW'(N - 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    logic             s;
    deb_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_ff #(
        .S    (S),
        .INIT (INIT)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (s)
    );

    // Next-state logic: a candidate level must be seen N cycles in a row, any
    // return to the current level abandons the candidate and clears the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LO: begin
                if (s) begin
                    if (N == 1) begin
                        state_d = ST_HI;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = CHK_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CHK_HI: begin
                if (!s) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_HI;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HI: begin
                if (!s) begin
                    if (N == 1) begin
                        state_d = ST_LO;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = CHK_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CHK_LO: begin
                if (s) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_LO;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and strobes; reset overrides everything and never strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT ? ST_HI : ST_LO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign q    = (state_q == ST_HI) || (state_q == CHK_LO);
    assign busy = (state_q == CHK_HI) || (state_q == CHK_LO);
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_deb.sv
// Testbench for deb: four differently parameterised instances share one input
// and reset; each is compared every cycle against a run-length reference model.
module tb_deb;

    localparam int NI = 4;

    logic clk;
    logic rstSig;
    logic inSig;

    logic qO    [NI];
    logic riseO [NI];
    logic fallO [NI];
    logic busyO [NI];

    int nP    [NI] = '{4, 1, 16, 8};
    int sP    [NI] = '{2, 3, 2, 2};
    logic initP [NI] = '{1'b0, 1'b1, 1'b0, 1'b0};

    // Reference model state: input history, modelled level, run length of disagreement.
    logic [7:0] histM  [NI];
    logic       qM     [NI];
    int         runM   [NI];
    logic       riseM  [NI];
    logic       fallM  [NI];

    int errors = 0;
    int checks = 0;
    int stepNo = 0;
    int rise0Step;

    deb #(.N(4),  .S(2), .INIT(1'b0)) dut0 (.clk(clk), .rst(rstSig), .in(inSig),
        .q(qO[0]), .rise(riseO[0]), .fall(fallO[0]), .busy(busyO[0]));
    deb #(.N(1),  .S(3), .INIT(1'b1)) dut1 (.clk(clk), .rst(rstSig), .in(inSig),
        .q(qO[1]), .rise(riseO[1]), .fall(fallO[1]), .busy(busyO[1]));
    deb #(.N(16), .S(2), .INIT(1'b0)) dut2 (.clk(clk), .rst(rstSig), .in(inSig),
        .q(qO[2]), .rise(riseO[2]), .fall(fallO[2]), .busy(busyO[2]));
    deb #(.N(8),  .S(2), .INIT(1'b0)) dut3 (.clk(clk), .rst(rstSig), .in(inSig),
        .q(qO[3]), .rise(riseO[3]), .fall(fallO[3]), .busy(busyO[3]));

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock edge of the model: the level seen by the qualifier is the input
    // from S edges ago; q flips once it has disagreed with q for N edges running.
    task automatic modelEdge(input logic inV, input logic rstV);
        for (int k = 0; k < NI; k++) begin
            logic sOld;
            riseM[k] = 1'b0;
            fallM[k] = 1'b0;
            if (rstV) begin
                histM[k] = {8{initP[k]}};
                qM[k]    = initP[k];
                runM[k]  = 0;
            end else begin
                sOld     = histM[k][sP[k]-1];
                histM[k] = {histM[k][6:0], inV};
                if (sOld == qM[k]) begin
                    runM[k] = 0;
                end else begin
                    runM[k] = runM[k] + 1;
                    if (runM[k] == nP[k]) begin
                        qM[k]    = sOld;
                        riseM[k] = sOld;
                        fallM[k] = ~sOld;
                        runM[k]  = 0;
                    end
                end
            end
        end
    endtask

    // Compare one instance's outputs {q,rise,fall,busy} with the model.
    task automatic checkOutput(input int k);
        logic [3:0] obs;
        logic [3:0] exp;
        obs = {qO[k], riseO[k], fallO[k], busyO[k]};
        exp = {qM[k], riseM[k], fallM[k], (runM[k] > 0)};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL inst%0d step%0d qrfb observed=%b expected=%b", k, stepNo, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, advance the model, then check all instances.
    task automatic applyStimulus(input logic inV, input logic rstV);
        inSig  = inV;
        rstSig = rstV;
        @(posedge clk);
        modelEdge(inV, rstV);
        #1;
        stepNo++;
        for (int k = 0; k < NI; k++) checkOutput(k);
    endtask

    task automatic holdFor(input logic inV, input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(inV, 1'b0);
    endtask

    initial begin
        inSig  = 1'b1;
        rstSig = 1'b1;

        // Reset held three cycles with the input high.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1);
            checks++;
            assert ({qO[0], riseO[0], fallO[0], busyO[0]} === 4'b0000) else begin
                errors++;
                $error("[TB] FAIL reset_outputs observed=%b expected=0000",
                       {qO[0], riseO[0], fallO[0], busyO[0]});
            end
        end

        // Release reset with input already high: N=4,S=2 instance rises on edge 6.
        rise0Step = 0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (riseO[0] === 1'b1 && rise0Step == 0) rise0Step = i;
        end
        checks++;
        assert (rise0Step === 6) else begin
            errors++;
            $error("[TB] FAIL first_rise_edge observed=%0d expected=6", rise0Step);
        end

        // Settle low, then a 3-cycle glitch that the N=4 instance must reject.
        holdFor(1'b0, 40);
        holdFor(1'b1, 3);
        holdFor(1'b0, 12);
        checks++;
        assert (qO[0] === 1'b0) else begin
            errors++;
            $error("[TB] FAIL glitch_q observed=%b expected=0", qO[0]);
        end

        // Bounce 1,0,1,1,0,1 then settle high.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        holdFor(1'b1, 30);
        checks++;
        assert (qO[3] === 1'b1) else begin
            errors++;
            $error("[TB] FAIL bounce_settle_q observed=%b expected=1", qO[3]);
        end

        // Single low cycle from a stable high: only the N=1 instance follows it.
        applyStimulus(1'b0, 1'b0);
        holdFor(1'b1, 10);

        // Reset in the middle of the N=16 qualification, then requalify.
        holdFor(1'b0, 30);
        holdFor(1'b1, 12);
        applyStimulus(1'b1, 1'b1);
        holdFor(1'b1, 25);
        checks++;
        assert (qO[2] === 1'b1) else begin
            errors++;
            $error("[TB] FAIL requalify_q observed=%b expected=1", qO[2]);
        end

        // Random runs of varying length with occasional resets.
        for (int r = 0; r < 60; r++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                applyStimulus(lvl, ($urandom_range(0, 63) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
